// File: rtl/ofdm_bit_interleaver.sv
// 802.11a BPSK block interleaver: serial coded bits in, ping-pong buffered, serial interleaved bits out.
// Optional OFDM_BIT_INTERLEAVER_INVERSE_EN adds an Inverse input selecting the deinterleaving permutation.
module ofdm_bit_interleaver #(
  parameter int N_CBPS = 48
) (
  input  logic Clock,
  input  logic Reset,
  input  logic InValid,
  input  logic Input,
  output logic InReady,
  output logic OutValid,
  output logic Output,
  input  logic OutReady,
  output logic SymStart,
`ifdef OFDM_BIT_INTERLEAVER_INVERSE_EN
  input  logic Inverse,
`endif
  output logic Error
);
  localparam int COLS = N_CBPS / 16;
  localparam int AW   = $clog2(N_CBPS);
  localparam int CW   = $clog2(COLS + 1);
  localparam int RW   = 4;  // i div COLS is always below 16

  logic bank_mem [2][N_CBPS];

  logic          ready_en_q, ready_en_d;
  logic [1:0]    full_q, full_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wr_k_q, wr_k_d;
  logic [AW-1:0] rd_i_q, rd_i_d;
  logic [CW-1:0] rd_col_q, rd_col_d;
  logic [RW-1:0] rd_row_q, rd_row_d;
  logic          err_q, err_d;
  logic          accept, xfer, wr_last, rd_last;
  logic [AW-1:0] rd_addr;

  // Ready stays low until the first edge after reset release.
  assign InReady  = ready_en_q & ~full_q[wr_bank_q];
  assign OutValid = full_q[rd_bank_q];
  assign Output   = OutValid & bank_mem[rd_bank_q][rd_addr];
  assign SymStart = OutValid & (rd_i_q == '0);
  assign Error    = err_q;

`ifdef OFDM_BIT_INTERLEAVER_INVERSE_EN
  logic inv_q, inv_d;

  // Mode is resampled while idle at i = 0; both permutations map i = 0 to k = 0.
  always_comb begin
    inv_d = (rd_i_q == '0) ? Inverse : inv_q;
    if (inv_q) begin
      rd_addr = AW'(COLS * int'(rd_i_q[3:0]) + int'(rd_i_q >> 4));
    end else begin
      rd_addr = AW'(16 * int'(rd_col_q) + int'(rd_row_q));
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) inv_q <= 1'b0;
    else       inv_q <= inv_d;
  end
`else
  always_comb begin
    rd_addr = AW'(16 * int'(rd_col_q) + int'(rd_row_q));
  end
`endif

  always_comb begin
    accept     = InValid & InReady;
    xfer       = OutValid & OutReady;
    wr_last    = accept && (wr_k_q == AW'(N_CBPS - 1));
    rd_last    = xfer && (rd_i_q == AW'(N_CBPS - 1));
    ready_en_d = 1'b1;
    full_d     = full_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    wr_k_d     = wr_k_q;
    rd_i_d     = rd_i_q;
    rd_col_d   = rd_col_q;
    rd_row_d   = rd_row_q;
    err_d      = err_q | (InValid & ~InReady);

    if (accept) begin
      if (wr_last) begin
        wr_k_d            = '0;
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_k_d = wr_k_q + 1'b1;
      end
    end

    // Write and read banks always differ here, so both flag updates survive.
    if (xfer) begin
      if (rd_last) begin
        rd_i_d            = '0;
        rd_col_d          = '0;
        rd_row_d          = '0;
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end else begin
        rd_i_d = rd_i_q + 1'b1;
        if (rd_col_q == CW'(COLS - 1)) begin
          rd_col_d = '0;
          rd_row_d = rd_row_q + 1'b1;
        end else begin
          rd_col_d = rd_col_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ready_en_q <= 1'b0;
      full_q     <= '0;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      wr_k_q     <= '0;
      rd_i_q     <= '0;
      rd_col_q   <= '0;
      rd_row_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      ready_en_q <= ready_en_d;
      full_q     <= full_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      wr_k_q     <= wr_k_d;
      rd_i_q     <= rd_i_d;
      rd_col_q   <= rd_col_d;
      rd_row_q   <= rd_row_d;
      err_q      <= err_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (accept) bank_mem[wr_bank_q][wr_k_q] <= Input;
  end

endmodule
